// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory pipeline stage (M register, data-memory handshake, W register)
//
// The M register captures the execute-stage instruction. A load or store held
// in M issues a data-memory request. The request stays up, and the pipeline
// stalls, until the memory raises MemReady. Results are then registered into
// the writeback (W) register. A stalled edge inserts a bubble into W.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   ValidE, FlushE      E-side instruction valid / kill
//   PCSrcE, RegWriteE,
//   MemtoRegE, MemWriteE  E-side control bits
//   RdE, ALUResultE,
//   WriteDataE          E-side destination, address/result, store data
//   StallM              upstream must hold the E-side inputs stable
//   MemReq, MemWe,
//   MemAddr, MemWData   data-memory request (the address is word-aligned)
//   MemReady, MemRData  memory handshake and read data
//   ValidW ... AlignErrW  registered writeback-stage outputs
// -----------------------------------------------------------------------------
module mem_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        ValidE,
   input  logic        FlushE,
   input  logic        PCSrcE,
   input  logic        RegWriteE,
   input  logic        MemtoRegE,
   input  logic        MemWriteE,
   input  logic [3:0]  RdE,
   input  logic [31:0] ALUResultE,
   input  logic [31:0] WriteDataE,
   output logic        StallM,
   output logic        MemReq,
   output logic        MemWe,
   output logic [31:0] MemAddr,
   output logic [31:0] MemWData,
   input  logic        MemReady,
   input  logic [31:0] MemRData,
   output logic        ValidW,
   output logic        PCSrcW,
   output logic        RegWriteW,
   output logic        MemtoRegW,
   output logic [3:0]  RdW,
   output logic [31:0] ALUOutW,
   output logic [31:0] ReadDataW,
   output logic        AlignErrW
);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t      state_q, state_d;

   logic        valid_m_q;
   logic        pcsrc_m_q;
   logic        regwrite_m_q;
   logic        memtoreg_m_q;
   logic        memwrite_m_q;
   logic [3:0]  rd_m_q;
   logic [31:0] alu_m_q;
   logic [31:0] wdata_m_q;

   logic        mem_instr;

   assign mem_instr = valid_m_q & (memtoreg_m_q | memwrite_m_q);

   // ---------------------------------------------------------------- M register
   // The register is frozen while the stall is active. This freeze keeps the
   // request address and data stable for the whole access.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_m_q    <= 1'b0;
         pcsrc_m_q    <= 1'b0;
         regwrite_m_q <= 1'b0;
         memtoreg_m_q <= 1'b0;
         memwrite_m_q <= 1'b0;
         rd_m_q       <= '0;
         alu_m_q      <= '0;
         wdata_m_q    <= '0;
      end else if (!StallM) begin
         valid_m_q    <= ValidE & ~FlushE;
         pcsrc_m_q    <= PCSrcE;
         regwrite_m_q <= RegWriteE;
         memtoreg_m_q <= MemtoRegE;
         memwrite_m_q <= MemWriteE;
         rd_m_q       <= RdE;
         alu_m_q      <= ALUResultE;
         wdata_m_q    <= WriteDataE;
      end
   end

   // ------------------------------------------------------------- FSM register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ----------------------------------------- request outputs and next state
   // The request is the same in IDLE and WAIT. The state records only whether
   // an access is already outstanding. A MemReady pulse with no request is
   // ignored and does not change the state.
   always_comb begin
      MemReq   = 1'b0;
      MemWe    = 1'b0;
      MemAddr  = '0;
      MemWData = '0;
      StallM   = 1'b0;
      state_d  = state_q;
      if (mem_instr) begin
         MemReq   = 1'b1;
         MemWe    = memwrite_m_q;
         MemAddr  = {alu_m_q[31:2], 2'b00};
         MemWData = wdata_m_q;
         if (MemReady) begin
            state_d = IDLE;
         end else begin
            StallM  = 1'b1;
            state_d = WAIT;
         end
      end
   end

   // ---------------------------------------------------------------- W register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ValidW    <= 1'b0;
         PCSrcW    <= 1'b0;
         RegWriteW <= 1'b0;
         MemtoRegW <= 1'b0;
         AlignErrW <= 1'b0;
         RdW       <= '0;
         ALUOutW   <= '0;
         ReadDataW <= '0;
      end else if (StallM) begin
         // Bubble: clear the controls and keep the data fields.
         ValidW    <= 1'b0;
         PCSrcW    <= 1'b0;
         RegWriteW <= 1'b0;
         MemtoRegW <= 1'b0;
         AlignErrW <= 1'b0;
      end else begin
         ValidW    <= valid_m_q;
         PCSrcW    <= pcsrc_m_q & valid_m_q;
         RegWriteW <= regwrite_m_q & valid_m_q;
         MemtoRegW <= memtoreg_m_q & valid_m_q;
         AlignErrW <= mem_instr & (alu_m_q[1:0] != 2'b00);
         RdW       <= rd_m_q;
         ALUOutW   <= alu_m_q;
         // Not stalled with a load in M means the load completes this edge.
         if (mem_instr && memtoreg_m_q) begin
            ReadDataW <= MemRData;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage
// -----------------------------------------------------------------------------
module tb_mem_stage;

   logic        clk;
   logic        reset;
   logic        ValidE, FlushE, PCSrcE, RegWriteE, MemtoRegE, MemWriteE;
   logic [3:0]  RdE;
   logic [31:0] ALUResultE, WriteDataE;
   logic        StallM, MemReq, MemWe;
   logic [31:0] MemAddr, MemWData;
   logic        MemReady;
   logic [31:0] MemRData;
   logic        ValidW, PCSrcW, RegWriteW, MemtoRegW;
   logic [3:0]  RdW;
   logic [31:0] ALUOutW, ReadDataW;
   logic        AlignErrW;

   mem_stage dut (
      .clk        (clk),
      .reset      (reset),
      .ValidE     (ValidE),
      .FlushE     (FlushE),
      .PCSrcE     (PCSrcE),
      .RegWriteE  (RegWriteE),
      .MemtoRegE  (MemtoRegE),
      .MemWriteE  (MemWriteE),
      .RdE        (RdE),
      .ALUResultE (ALUResultE),
      .WriteDataE (WriteDataE),
      .StallM     (StallM),
      .MemReq     (MemReq),
      .MemWe      (MemWe),
      .MemAddr    (MemAddr),
      .MemWData   (MemWData),
      .MemReady   (MemReady),
      .MemRData   (MemRData),
      .ValidW     (ValidW),
      .PCSrcW     (PCSrcW),
      .RegWriteW  (RegWriteW),
      .MemtoRegW  (MemtoRegW),
      .RdW        (RdW),
      .ALUOutW    (ALUOutW),
      .ReadDataW  (ReadDataW),
      .AlignErrW  (AlignErrW)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid, flush, pcsrc, regwr, m2r, memwr;
      logic [3:0]  rd;
      logic [31:0] alu, wdata, rdata;
      logic        exp_req, exp_we;
      logic [31:0] exp_addr;
      logic        exp_validw, exp_regw, exp_pcsw, exp_m2rw, exp_align;
   } vec_t;

   typedef struct {
      logic        req, we;
      logic [31:0] addr, wdata;
   } mexp_t;

   typedef struct {
      int          idx;
      logic        validw, regw, pcsw, m2rw, align;
      logic [3:0]  rd;
      logic [31:0] alu, rdata;
   } wexp_t;

   localparam int NV = 8;
   vec_t  vecs [NV];
   mexp_t m_q[$];
   wexp_t w_q[$];
   int    n_cmp = 0;
   int    n_err = 0;
   logic [31:0] model_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_e(input logic v, input logic f, input logic pc, input logic rw,
                          input logic m2r, input logic mw, input logic [3:0] rd,
                          input logic [31:0] alu, input logic [31:0] wd);
      ValidE = v; FlushE = f; PCSrcE = pc; RegWriteE = rw;
      MemtoRegE = m2r; MemWriteE = mw; RdE = rd; ALUResultE = alu; WriteDataE = wd;
   endtask

   task automatic drive_idle();
      drive_e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
   endtask

   initial begin
      mexp_t me;
      wexp_t we;

      //           v    f    pc   rw   m2r  mw   rd    alu           wdata         rdata          req  we   addr          vW   rwW  pcW  m2rW al
      vecs[0] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,4'd5, 32'h0000_1234,32'h0,        32'h0,         1'b0,1'b0,32'h0,        1'b1,1'b1,1'b0,1'b0,1'b0};
      vecs[1] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,4'd0, 32'h0000_0204,32'h0000_CAFE,32'h0,         1'b1,1'b1,32'h0000_0204,1'b1,1'b0,1'b0,1'b0,1'b0};
      vecs[2] = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,4'd3, 32'h0000_0102,32'h0,        32'h1111_2222, 1'b1,1'b0,32'h0000_0100,1'b1,1'b1,1'b0,1'b1,1'b1};
      vecs[3] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,4'd0, 32'h0000_0300,32'h0000_0BAD,32'h0,         1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0};
      vecs[4] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,4'd0, 32'h0000_0040,32'h0,        32'h0,         1'b0,1'b0,32'h0,        1'b1,1'b0,1'b1,1'b0,1'b0};
      vecs[5] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,4'd8, 32'h0000_0500,32'h0000_0005,32'h1234_5678, 1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0};
      vecs[6] = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,4'd7, 32'h0000_0008,32'h0,        32'hA5A5_A5A5, 1'b1,1'b0,32'h0000_0008,1'b1,1'b1,1'b0,1'b1,1'b0};
      vecs[7] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,4'd0, 32'h0000_0207,32'h0000_0077,32'h0,         1'b1,1'b1,32'h0000_0204,1'b1,1'b0,1'b0,1'b0,1'b1};

      reset = 1'b1;
      drive_idle();
      MemReady = 1'b0;
      MemRData = 32'd0;
      model_rdata = 32'd0;

      // ---------------------------------------------------- reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ValidW",    {31'd0, ValidW},    32'd0);
      chk("rst_MemReq",    {31'd0, MemReq},    32'd0);
      chk("rst_StallM",    {31'd0, StallM},    32'd0);
      chk("rst_RegWriteW", {31'd0, RegWriteW}, 32'd0);
      chk("rst_AlignErrW", {31'd0, AlignErrW}, 32'd0);
      chk("rst_ALUOutW",   ALUOutW,            32'd0);
      chk("rst_ReadDataW", ReadDataW,          32'd0);
      chk("rst_MemAddr",   MemAddr,            32'd0);
      step();
      reset = 1'b0;

      // ---------------------------------- table vectors, zero-wait memory
      MemReady = 1'b1;
      for (int j = 0; j <= NV + 1; j++) begin
         if (j < NV) begin
            drive_e(vecs[j].valid, vecs[j].flush, vecs[j].pcsrc, vecs[j].regwr,
                    vecs[j].m2r, vecs[j].memwr, vecs[j].rd, vecs[j].alu, vecs[j].wdata);
            me.req = vecs[j].exp_req; me.we = vecs[j].exp_we;
            me.addr = vecs[j].exp_addr; me.wdata = vecs[j].wdata;
            m_q.push_back(me);
            if (vecs[j].exp_validw && vecs[j].exp_m2rw) model_rdata = vecs[j].rdata;
            we.idx = j; we.validw = vecs[j].exp_validw; we.regw = vecs[j].exp_regw;
            we.pcsw = vecs[j].exp_pcsw; we.m2rw = vecs[j].exp_m2rw; we.align = vecs[j].exp_align;
            we.rd = vecs[j].rd; we.alu = vecs[j].alu; we.rdata = model_rdata;
            w_q.push_back(we);
         end else begin
            drive_idle();
         end
         if (j >= 1) MemRData = vecs[j-1].rdata;
         @(negedge clk);
         if (j >= 1 && m_q.size() > 0) begin
            me = m_q.pop_front();
            chk("tbl_StallM", {31'd0, StallM}, 32'd0);
            chk("tbl_MemReq", {31'd0, MemReq}, {31'd0, me.req});
            if (me.req) begin
               chk("tbl_MemWe",    {31'd0, MemWe}, {31'd0, me.we});
               chk("tbl_MemAddr",  MemAddr,        me.addr);
               chk("tbl_MemWData", MemWData,       me.wdata);
            end
         end
         if (j >= 2 && w_q.size() > 0) begin
            we = w_q.pop_front();
            chk("tbl_ValidW",    {31'd0, ValidW},    {31'd0, we.validw});
            chk("tbl_RegWriteW", {31'd0, RegWriteW}, {31'd0, we.regw});
            chk("tbl_PCSrcW",    {31'd0, PCSrcW},    {31'd0, we.pcsw});
            chk("tbl_MemtoRegW", {31'd0, MemtoRegW}, {31'd0, we.m2rw});
            chk("tbl_AlignErrW", {31'd0, AlignErrW}, {31'd0, we.align});
            chk("tbl_ReadDataW", ReadDataW,          we.rdata);
            if (we.validw) begin
               chk("tbl_RdW",     {28'd0, RdW}, {28'd0, we.rd});
               chk("tbl_ALUOutW", ALUOutW,      we.alu);
            end
            $display("vec %0d: ValidW=%b RegWriteW=%b RdW=%0d ALUOutW=%h ReadDataW=%h AlignErrW=%b",
                     we.idx, ValidW, RegWriteW, RdW, ALUOutW, ReadDataW, AlignErrW);
         end
         step();
      end

      // ------------------------- load at 0x100 with three wait cycles
      drive_e(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 32'h0000_0100, 32'h0);
      MemReady = 1'b0;
      step();
      // The upstream holds the next instruction while the stall is active.
      drive_e(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 32'h0000_0055, 32'h0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("wait_StallM",  {31'd0, StallM}, 32'd1);
         chk("wait_MemReq",  {31'd0, MemReq}, 32'd1);
         chk("wait_MemWe",   {31'd0, MemWe},  32'd0);
         chk("wait_MemAddr", MemAddr,         32'h0000_0100);
         chk("wait_ValidW",  {31'd0, ValidW}, 32'd0);
         $display("load wait cycle %0d: StallM=%b MemAddr=%h", k, StallM, MemAddr);
         step();
      end
      MemReady = 1'b1;
      MemRData = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("done_StallM",  {31'd0, StallM}, 32'd0);
      chk("done_MemReq",  {31'd0, MemReq}, 32'd1);
      chk("done_MemAddr", MemAddr,         32'h0000_0100);
      step();
      drive_idle();
      MemRData = 32'h0BAD_0BAD;   // MemReady stays high with no request and must be ignored
      @(negedge clk);
      chk("ld_ValidW",    {31'd0, ValidW},    32'd1);
      chk("ld_MemtoRegW", {31'd0, MemtoRegW}, 32'd1);
      chk("ld_RdW",       {28'd0, RdW},       32'd9);
      chk("ld_ReadDataW", ReadDataW,          32'hDEAD_BEEF);
      chk("ld_MemReq",    {31'd0, MemReq},    32'd0);
      $display("load complete: ReadDataW=%h MemtoRegW=%b", ReadDataW, MemtoRegW);
      step();
      @(negedge clk);
      chk("alu2_ValidW",    {31'd0, ValidW},    32'd1);
      chk("alu2_RdW",       {28'd0, RdW},       32'd2);
      chk("alu2_ALUOutW",   ALUOutW,            32'h0000_0055);
      chk("alu2_ReadDataW", ReadDataW,          32'hDEAD_BEEF);
      chk("alu2_MemtoRegW", {31'd0, MemtoRegW}, 32'd0);
      $display("held op after load: RdW=%0d ALUOutW=%h", RdW, ALUOutW);
      step();

      // ------------------------------------------ reset during WAIT
      MemReady = 1'b0;
      drive_e(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 32'h0000_0099, 32'h0);
      step();
      drive_e(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h0000_0040, 32'h1);
      step();
      drive_idle();
      @(negedge clk);
      chk("pre_ValidW", {31'd0, ValidW}, 32'd1);
      chk("pre_StallM", {31'd0, StallM}, 32'd1);
      chk("pre_MemReq", {31'd0, MemReq}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("arst_MemReq",    {31'd0, MemReq},    32'd0);
      chk("arst_StallM",    {31'd0, StallM},    32'd0);
      chk("arst_ValidW",    {31'd0, ValidW},    32'd0);
      chk("arst_RegWriteW", {31'd0, RegWriteW}, 32'd0);
      $display("reset in WAIT: MemReq=%b StallM=%b ValidW=%b", MemReq, StallM, ValidW);
      step();
      reset = 1'b0;
      drive_e(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6, 32'h0000_0066, 32'h0);
      @(negedge clk);
      chk("post_MemReq", {31'd0, MemReq}, 32'd0);
      chk("post_StallM", {31'd0, StallM}, 32'd0);
      step();
      drive_idle();
      @(negedge clk);
      chk("post2_StallM", {31'd0, StallM}, 32'd0);
      chk("post2_MemReq", {31'd0, MemReq}, 32'd0);
      step();
      @(negedge clk);
      chk("post_ValidW", {31'd0, ValidW},  32'd1);
      chk("post_RdW",    {28'd0, RdW},     32'd6);
      chk("post_ALUOutW", ALUOutW,         32'h0000_0066);
      $display("after reset release: ValidW=%b RdW=%0d", ValidW, RdW);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
